// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - shared FSM encodings and constants for the SPI command decoder
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_CHECK  = 3'd2,
        ST_COMMIT = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    // Command byte bit that marks a register write.
    localparam int CMD_WRITE_BIT = 7;

    // Starting value of the running XOR checksum.
    localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/spi_cmd_decoder_sync_2ff.sv
// rtl/spi_cmd_decoder_sync_2ff.sv - two-flop synchronizer with parameterized reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both stages come out of reset at RESET_VAL.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - frames SPI bytes into register writes; optional checksum via SPI_CMD_CHECKSUM_EN
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int DATA_BYTES = 2,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cs,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_byte,
    output logic                    o_wr_en,
    output logic [ADDR_W-1:0]       o_wr_addr,
    output logic [8*DATA_BYTES-1:0] o_wr_data,
    output logic                    o_frame_err,
    output logic                    o_busy
);

    localparam int         DW       = 8 * DATA_BYTES;
    localparam logic [2:0] LAST_CNT = 3'(DATA_BYTES);

    logic cs_sync;
    logic cs_active;

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic [2:0]        cnt_inc;
    logic [DW-1:0]     shift, shift_d;
    logic [DW+7:0]     shift_ext;
    logic [ADDR_W-1:0] addr, addr_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [DW-1:0]     wr_data_d;
    logic              err, err_d;
    logic              armed, armed_d;
    logic              rx;
    logic              cmd_ok;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [7:0]        csum, csum_d;
`endif

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_cs),
        .q     (cs_sync)
    );

    assign cs_active = ~cs_sync;
    assign rx        = i_rx_valid & cs_active;
    assign cnt_inc   = cnt + 3'd1;
    assign shift_ext = {shift, i_rx_byte};
    assign cmd_ok    = i_rx_byte[CMD_WRITE_BIT] &&
                       (32'(i_rx_byte[ADDR_W-1:0]) < 32'(NUM_REGS));

    assign o_wr_en     = (state == ST_COMMIT);
    assign o_busy      = (state == ST_DATA) || (state == ST_CHECK) || (state == ST_COMMIT);
    assign o_frame_err = err;

    // Next-state logic; error pulses are registered so they land one cycle after their cause.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        shift_d   = shift;
        addr_d    = addr;
        wr_addr_d = o_wr_addr;
        wr_data_d = o_wr_data;
        err_d     = 1'b0;
        armed_d   = armed;
`ifdef SPI_CMD_CHECKSUM_EN
        csum_d    = csum;
`endif
        case (state)
            ST_IDLE: begin
                armed_d = 1'b0;
                if (rx) begin
                    if (cmd_ok) begin
                        addr_d  = i_rx_byte[ADDR_W-1:0];
                        shift_d = '0;
                        cnt_d   = 3'd0;
`ifdef SPI_CMD_CHECKSUM_EN
                        csum_d  = CSUM_SEED ^ i_rx_byte;
`endif
                        state_d = ST_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DATA: begin
                // A CS release takes priority over a byte arriving in the same cycle.
                if (!cs_active) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_rx_valid) begin
                    shift_d = shift_ext[DW-1:0];
                    cnt_d   = cnt_inc;
`ifdef SPI_CMD_CHECKSUM_EN
                    csum_d  = csum ^ i_rx_byte;
                    if (cnt_inc == LAST_CNT) begin
                        state_d = ST_CHECK;
                    end
`else
                    if (cnt_inc == LAST_CNT) begin
                        wr_addr_d = addr;
                        wr_data_d = shift_ext[DW-1:0];
                        state_d   = ST_COMMIT;
                    end
`endif
                end
            end
`ifdef SPI_CMD_CHECKSUM_EN
            ST_CHECK: begin
                if (!cs_active) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (i_rx_valid) begin
                    if (i_rx_byte == csum) begin
                        wr_addr_d = addr;
                        wr_data_d = shift;
                        state_d   = ST_COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
`endif
            ST_COMMIT: begin
                armed_d = 1'b1;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Extra bytes only count as overrun once this frame has written.
                if (!cs_active) begin
                    state_d = ST_IDLE;
                end else if (i_rx_valid && armed) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; address/data load on entry to COMMIT so they change with o_wr_en.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            shift     <= '0;
            addr      <= '0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            err       <= 1'b0;
            armed     <= 1'b0;
`ifdef SPI_CMD_CHECKSUM_EN
            csum      <= CSUM_SEED;
`endif
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            shift     <= shift_d;
            addr      <= addr_d;
            o_wr_addr <= wr_addr_d;
            o_wr_data <= wr_data_d;
            err       <= err_d;
            armed     <= armed_d;
`ifdef SPI_CMD_CHECKSUM_EN
            csum      <= csum_d;
`endif
        end
    end

endmodule
